// File: rtl/array_reg_or_reduce_if.sv
// rtl/array_reg_or_reduce_if.sv - write port and flat/reduced read bus of the OR-reduced register array
interface array_reg_or_reduce_if #(
    parameter int ELEMENTS = 4,
    parameter int WIDTH    = 8
);
    localparam int IDX_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

    logic                      enable;
    logic [IDX_W-1:0]          index;
    logic [WIDTH-1:0]          element;
    logic [ELEMENTS*WIDTH-1:0] array;
    logic [WIDTH-1:0]          result;

    modport master (
        output enable,
        output index,
        output element,
        input  array,
        input  result
    );

    modport slave (
        input  enable,
        input  index,
        input  element,
        output array,
        output result
    );
endinterface

// File: rtl/array_reg_or_reduce.sv
// rtl/array_reg_or_reduce.sv - indexed-write register array with combinational bitwise-OR reduction
module array_reg_storage #(
    parameter int ELEMENTS = 4,
    parameter int WIDTH    = 8,
    parameter int IDX_W    = 2
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic                      enable,
    input  logic [IDX_W-1:0]          index,
    input  logic [WIDTH-1:0]          element,
    output logic [ELEMENTS*WIDTH-1:0] array
);
    logic [WIDTH-1:0] words [ELEMENTS];

    // Per-word compare: an index >= ELEMENTS matches no word, so it never writes or aliases.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < ELEMENTS; i++) begin
                words[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ELEMENTS; i++) begin
                if (enable && (index == IDX_W'(i))) begin
                    words[i] <= element;
                end
            end
        end
    end

    for (genvar g = 0; g < ELEMENTS; g++) begin : g_flat
        assign array[g*WIDTH +: WIDTH] = words[g];
    end
endmodule

module or_reduce #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
) (
    input  logic [SIZE*WIDTH-1:0] flat,
    output logic [WIDTH-1:0]      result
);
    logic [WIDTH-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < SIZE; i++) begin
            acc = acc | flat[i*WIDTH +: WIDTH];
        end
    end

    assign result = acc;
endmodule

module array_reg_or_reduce #(
    parameter int ELEMENTS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                    clock,
    input  logic                    clear_n,
    array_reg_or_reduce_if.slave    bus
);
    localparam int IDX_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

    array_reg_storage #(
        .ELEMENTS (ELEMENTS),
        .WIDTH    (WIDTH),
        .IDX_W    (IDX_W)
    ) u_storage (
        .clock   (clock),
        .clear_n (clear_n),
        .enable  (bus.enable),
        .index   (bus.index),
        .element (bus.element),
        .array   (bus.array)
    );

    // Reduction reads the published bus so result tracks array with no extra state.
    or_reduce #(
        .SIZE  (ELEMENTS),
        .WIDTH (WIDTH)
    ) u_or_reduce (
        .flat   (bus.array),
        .result (bus.result)
    );
endmodule

// File: tb/tb_array_reg_or_reduce.sv
// tb/tb_array_reg_or_reduce.sv - directed self-checking bench for array_reg_or_reduce
module tb_array_reg_or_reduce;
    logic clock;
    logic clear_n;
    int   n_tests;
    int   n_failed;

    array_reg_or_reduce_if #(.ELEMENTS(4), .WIDTH(8)) bus4 ();
    array_reg_or_reduce_if #(.ELEMENTS(3), .WIDTH(8)) bus3 ();

    array_reg_or_reduce #(.ELEMENTS(4), .WIDTH(8)) dut4 (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus4.slave)
    );

    array_reg_or_reduce #(.ELEMENTS(3), .WIDTH(8)) dut3 (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus3.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; drives the 4-word port, crosses one rising edge, returns at the next falling edge.
    task automatic cyc4(input logic en, input logic [1:0] idx, input logic [7:0] data);
        bus4.enable  = en;
        bus4.index   = idx;
        bus4.element = data;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cyc3(input logic en, input logic [1:0] idx, input logic [7:0] data);
        bus3.enable  = en;
        bus3.index   = idx;
        bus3.element = data;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk4(input string tag, input logic [31:0] exp_array, input logic [7:0] exp_result);
        check({tag, ".array"}, bus4.array, exp_array);
        check({tag, ".result"}, {24'h0, bus4.result}, {24'h0, exp_result});
    endtask

    task automatic chk3(input string tag, input logic [23:0] exp_array, input logic [7:0] exp_result);
        check({tag, ".array"}, {8'h0, bus3.array}, {8'h0, exp_array});
        check({tag, ".result"}, {24'h0, bus3.result}, {24'h0, exp_result});
    endtask

    initial begin
        n_tests      = 0;
        n_failed     = 0;
        clear_n      = 1'b0;
        bus4.enable  = 1'b0;
        bus4.index   = '0;
        bus4.element = '0;
        bus3.enable  = 1'b0;
        bus3.index   = '0;
        bus3.element = '0;

        // Reset held three cycles
        @(negedge clock);
        cyc4(1'b0, 2'd0, 8'h00);
        cyc4(1'b0, 2'd0, 8'h00);
        cyc4(1'b0, 2'd0, 8'h00);
        chk4("reset4", 32'h0000_0000, 8'h00);
        chk3("reset3", 24'h00_0000, 8'h00);

        // Writes are ignored while reset is low
        cyc4(1'b1, 2'd1, 8'h5a);
        chk4("reset_write", 32'h0000_0000, 8'h00);

        clear_n = 1'b1;

        // Sequential fill
        cyc4(1'b1, 2'd0, 8'haa);
        chk4("fill0", 32'h0000_00aa, 8'haa);
        cyc4(1'b1, 2'd1, 8'h11);
        chk4("fill1", 32'h0000_11aa, 8'hbb);
        cyc4(1'b1, 2'd2, 8'h72);
        chk4("fill2", 32'h0072_11aa, 8'hfb);
        cyc4(1'b1, 2'd3, 8'h88);
        chk4("fill3", 32'h8872_11aa, 8'hfb);

        // Enable gating
        cyc4(1'b0, 2'd0, 8'hff);
        chk4("gate", 32'h8872_11aa, 8'hfb);

        // Clearing via writes
        cyc4(1'b1, 2'd0, 8'h00);
        chk4("clr0", 32'h8872_1100, 8'hfb);
        cyc4(1'b1, 2'd1, 8'h00);
        chk4("clr1", 32'h8872_0000, 8'hfa);
        cyc4(1'b0, 2'd2, 8'h00);
        chk4("clr_dis", 32'h8872_0000, 8'hfa);
        cyc4(1'b1, 2'd3, 8'h00);
        chk4("clr3", 32'h0072_0000, 8'h72);

        // Back-to-back writes to the same index, last wins
        cyc4(1'b1, 2'd2, 8'h10);
        chk4("ovw_a", 32'h0010_0000, 8'h10);
        cyc4(1'b1, 2'd2, 8'h20);
        cyc4(1'b1, 2'd2, 8'h33);
        chk4("ovw_last", 32'h0033_0000, 8'h33);

        // Hold for five disabled cycles with toggling index/data
        for (int i = 0; i < 5; i++) begin
            cyc4(1'b0, 2'(i), 8'hc3 ^ 8'(i));
            chk4($sformatf("hold%0d", i), 32'h0033_0000, 8'h33);
        end

        // Asynchronous reset mid-run, overriding a pending write
        cyc4(1'b1, 2'd0, 8'h81);
        chk4("pre_rst", 32'h0033_0081, 8'hb3);
        bus4.enable  = 1'b1;
        bus4.index   = 2'd1;
        bus4.element = 8'h44;
        #2;
        clear_n = 1'b0;
        #1;
        chk4("async_rst", 32'h0000_0000, 8'h00);
        @(posedge clock);
        @(negedge clock);
        chk4("rst_over_write", 32'h0000_0000, 8'h00);

        // First write after release
        clear_n = 1'b1;
        cyc4(1'b1, 2'd3, 8'h06);
        chk4("post_rst", 32'h0600_0000, 8'h06);
        cyc4(1'b0, 2'd0, 8'h00);

        // Three-word instance: out-of-range index writes nothing
        cyc3(1'b1, 2'd0, 8'h01);
        cyc3(1'b1, 2'd1, 8'h02);
        cyc3(1'b1, 2'd2, 8'h04);
        chk3("e3_fill", 24'h04_0201, 8'h07);
        cyc3(1'b1, 2'd3, 8'h5a);
        chk3("e3_oor", 24'h04_0201, 8'h07);
        cyc3(1'b1, 2'd1, 8'h50);
        chk3("e3_after", 24'h04_5001, 8'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
